morse_key_receiver: RTL and testbench

Single-key ("straight key") Morse receiver for Mode 1. It takes one debounced key level and times each press and release in Morse units. Presses are classified as dots or dashes and assembled into the same morse_code/morse_len form the morse_decoder consumes. The receiver emits a one-cycle character strobe at each letter gap and a one-cycle word strobe at each word gap. It is the timed-input counterpart of buzzer_driver's timed output and can replace the three-button dot/dash/enter entry.

---
 rtl/morse_pkg.sv | 30 +++
 rtl/morse_key_receiver_if.sv | 29 ++
 rtl/morse_unit_timer.sv | 46 ++++
 rtl/morse_key_receiver.sv | 159 +++++++++++++++
 tb/tb_morse_key_receiver.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions.
// Used by morse_key_receiver, morse_unit_timer and the other Morse blocks.
// Contents: the receiver state enum, the element encodings, the character
// register widths and a helper that appends one element to a code.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MARK      = 2'd1,
    GAP       = 2'd2,
    WORD_WAIT = 2'd3
  } morse_rx_state_e;

  localparam logic MORSE_DOT  = 1'b0;
  localparam logic MORSE_DASH = 1'b1;

  localparam int MORSE_MAX_LEN = 5;
  localparam int MORSE_CODE_W  = 5;
  localparam int MORSE_LEN_W   = 3;

  // The newest element enters at bit 0, so the first element of the
  // character ends up at bit len-1.
  function automatic logic [MORSE_CODE_W-1:0] morse_append(
    input logic [MORSE_CODE_W-1:0] code,
    input logic                    elem
  );
    return {code[MORSE_CODE_W-2:0], elem};
  endfunction

endpackage : morse_pkg

// File: rtl/morse_key_receiver_if.sv
// Bundle for the straight-key receiver.
// Inputs to the receiver: en (receiver enable) and key_in (debounced key level).
// Outputs from the receiver: morse_code and morse_len (the character),
// char_valid, word_gap and err (one-cycle strobes), and key_active.
// master = the side that drives the key and consumes characters.
// slave  = the receiver itself.
interface morse_key_receiver_if;
  import morse_pkg::*;

  logic                    en;
  logic                    key_in;
  logic [MORSE_CODE_W-1:0] morse_code;
  logic [MORSE_LEN_W-1:0]  morse_len;
  logic                    char_valid;
  logic                    word_gap;
  logic                    err;
  logic                    key_active;

  modport master (
    output en, key_in,
    input  morse_code, morse_len, char_valid, word_gap, err, key_active
  );

  modport slave (
    input  en, key_in,
    output morse_code, morse_len, char_valid, word_gap, err, key_active
  );

endinterface : morse_key_receiver_if

// File: rtl/morse_unit_timer.sv
// Measures time in Morse units.
// The cycle counter runs 0..UNIT_CYCLES-1. The unit counter steps each time
// the cycle counter wraps and saturates at 7.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   clr          - restart both counters from zero on the next edge
//   unit_cnt_now - units elapsed counting the current cycle, i.e. the value
//                  the unit counter takes on this edge if clr is low
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic [2:0] unit_cnt_now
);

  localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [2:0]       unit_cnt_q, unit_cnt_d;
  logic             wrap;

  always_comb begin
    wrap         = (cyc_cnt_q == CYC_LAST);
    unit_cnt_now = (wrap && (unit_cnt_q != 3'd7)) ? unit_cnt_q + 3'd1 : unit_cnt_q;
    cyc_cnt_d    = wrap ? '0 : cyc_cnt_q + 1'b1;
    unit_cnt_d   = unit_cnt_now;
    if (clr) begin
      cyc_cnt_d  = '0;
      unit_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q  <= '0;
      unit_cnt_q <= 3'd0;
    end else begin
      cyc_cnt_q  <= cyc_cnt_d;
      unit_cnt_q <= unit_cnt_d;
    end
  end

endmodule : morse_unit_timer

// File: rtl/morse_key_receiver.sv
// Straight-key Morse receiver.
// Times each key press and release in Morse units. Each press becomes a dot
// or a dash and is appended to a character. A strobe is raised at each
// letter gap and at each word gap.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   bus.slave  - en, key_in in; morse_code, morse_len, char_valid,
//                word_gap, err, key_active out (all outputs registered)
module morse_key_receiver
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES      = 200000,
  parameter int DASH_UNITS       = 2,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  morse_key_receiver_if.slave  bus
);

  localparam logic [2:0] DASH_U   = 3'(DASH_UNITS);
  localparam logic [2:0] LETTER_U = 3'(LETTER_GAP_UNITS);
  // The timer restarts on entry to WORD_WAIT, which happens LETTER_GAP_UNITS
  // after the last release. Only the remaining part of the word gap is
  // counted there.
  localparam logic [2:0] WORD_REM_U = 3'(WORD_GAP_UNITS - LETTER_GAP_UNITS);
  localparam logic [MORSE_LEN_W-1:0] MAX_LEN = MORSE_LEN_W'(MORSE_MAX_LEN);

  logic sync1_q, key_s_q, key_active_q;

  morse_rx_state_e         state_q, state_d;
  logic [MORSE_CODE_W-1:0] code_q, code_d;
  logic [MORSE_LEN_W-1:0]  len_q, len_d;
  logic                    ovf_q, ovf_d;
  logic                    char_valid_q, char_valid_d;
  logic                    word_gap_q, word_gap_d;
  logic                    err_q, err_d;

  logic [2:0] units_now;
  logic       elem;
  logic       timer_clr;

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clr          (timer_clr),
    .unit_cnt_now (units_now)
  );

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    char_valid_d = 1'b0;
    word_gap_d   = 1'b0;
    err_d        = 1'b0;
    // Press length includes the cycle in which the release is seen.
    // A press of D cycles therefore yields floor(D/UNIT_CYCLES) units.
    elem         = (units_now >= DASH_U) ? MORSE_DASH : MORSE_DOT;

    if (!bus.en) begin
      state_d = IDLE;
      code_d  = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_s_q) begin
            state_d = MARK;
            code_d  = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        MARK: begin
          if (!key_s_q) begin
            state_d = GAP;
            if (len_q < MAX_LEN) begin
              code_d = morse_append(code_q, elem);
              len_d  = len_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        GAP: begin
          // A press arriving on the threshold cycle wins and extends the
          // current character.
          if (key_s_q) begin
            state_d = MARK;
          end else if (units_now >= LETTER_U) begin
            state_d = WORD_WAIT;
            if (ovf_q) begin
              err_d  = 1'b1;
              code_d = '0;
              len_d  = '0;
              ovf_d  = 1'b0;
            end else begin
              char_valid_d = 1'b1;
            end
          end
        end
        WORD_WAIT: begin
          if (key_s_q) begin
            state_d = MARK;
            code_d  = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
          end else if (units_now >= WORD_REM_U) begin
            state_d    = IDLE;
            word_gap_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    timer_clr = !bus.en || (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      key_s_q      <= 1'b0;
      key_active_q <= 1'b0;
      state_q      <= IDLE;
      code_q       <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      char_valid_q <= 1'b0;
      word_gap_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= bus.key_in;
      key_s_q      <= sync1_q;
      key_active_q <= key_s_q;
      state_q      <= state_d;
      code_q       <= code_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      char_valid_q <= char_valid_d;
      word_gap_q   <= word_gap_d;
      err_q        <= err_d;
    end
  end

  assign bus.morse_code = code_q;
  assign bus.morse_len  = len_q;
  assign bus.char_valid = char_valid_q;
  assign bus.word_gap   = word_gap_q;
  assign bus.err        = err_q;
  assign bus.key_active = key_active_q;

endmodule : morse_key_receiver

// File: tb/tb_morse_key_receiver.sv
module tb_morse_key_receiver;
  import morse_pkg::*;

  localparam int UNIT = 10;

  // Delay from driving key_in to the character strobe: 2 synchronizer
  // cycles, 1 FSM cycle and 3 units. The word strobe follows 4 units later.
  localparam int CHAR_LAT = 3 + 3 * UNIT;
  localparam int WORD_LAT = 3 + 7 * UNIT;

  localparam int EV_CHAR = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_WORD = 2;

  typedef struct {
    int       kind;
    logic [4:0] code;
    logic [2:0] len;
    int       cyc;
  } ev_t;

  typedef struct {
    string      name;
    int         n;
    int         press[6];
    int         gap;
    bit         is_err;
    logic [4:0] code;
    logic [2:0] len;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];
  vec_t vecs[9];

  morse_key_receiver_if bus();

  morse_key_receiver #(
    .UNIT_CYCLES      (UNIT),
    .DASH_UNITS       (2),
    .LETTER_GAP_UNITS (3),
    .WORD_GAP_UNITS   (7)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int kind, input logic [4:0] code,
                          input logic [2:0] len, input int at);
    ev_t e;
    e.kind = kind; e.code = code; e.len = len; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: missing events, %0d outstanding, want 0 (next kind %0d at cycle %0d)",
               name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // Scoreboard: every strobe the DUT produces is matched against the
  // oldest expected event.
  always @(negedge clk) begin
    if (bus.char_valid || bus.err || bus.word_gap) begin
      ev_t act;
      ev_t e;
      vectors++;
      act.kind = bus.err ? EV_ERR : (bus.word_gap ? EV_WORD : EV_CHAR);
      act.code = bus.morse_code;
      act.len  = bus.morse_len;
      act.cyc  = cyc;
      if ((32'(bus.char_valid) + 32'(bus.err) + 32'(bus.word_gap)) > 1) begin
        miscompares++;
        $display("FAIL strobe_excl: cv=%0b err=%0b wg=%0b at cycle %0d, want one at a time",
                 bus.char_valid, bus.err, bus.word_gap, cyc);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: kind=%0d code=%b len=%0d at cycle %0d, want none",
                 act.kind, act.code, act.len, act.cyc);
      end else begin
        e = exp_q.pop_front();
        if (act.kind != e.kind || act.cyc != e.cyc ||
            (e.kind != EV_WORD && (act.code != e.code || act.len != e.len))) begin
          miscompares++;
          $display("FAIL strobe: got kind=%0d code=%b len=%0d cyc=%0d, want kind=%0d code=%b len=%0d cyc=%0d",
                   act.kind, act.code, act.len, act.cyc, e.kind, e.code, e.len, e.cyc);
        end else begin
          $display("ok   strobe kind=%0d code=%b len=%0d cyc=%0d", act.kind, act.code, act.len, act.cyc);
        end
      end
    end
  end

  // Drive a sequence of presses; returns the cycle of the final release.
  task automatic key_seq(input int n, input int press[6], input int gap, output int rel);
    rel = 0;
    for (int i = 0; i < n; i++) begin
      bus.key_in = 1'b1;
      tick(press[i]);
      bus.key_in = 1'b0;
      rel = cyc;
      if (i < n - 1) tick(gap);
    end
  endtask

  initial begin
    int rel;
    int p1[6];
    logic [11:0] outs;

    vecs[0] = '{"A_dot_dash",   2, '{10, 30,  0,  0,  0,  0}, 10, 1'b0, 5'b00001, 3'd2};
    vecs[1] = '{"press19_dot",  1, '{19,  0,  0,  0,  0,  0}, 10, 1'b0, 5'b00000, 3'd1};
    vecs[2] = '{"press20_dash", 1, '{20,  0,  0,  0,  0,  0}, 10, 1'b0, 5'b00001, 3'd1};
    vecs[3] = '{"five_dashes",  5, '{30, 30, 30, 30, 30,  0}, 10, 1'b0, 5'b11111, 3'd5};
    vecs[4] = '{"six_dots_err", 6, '{10, 10, 10, 10, 10, 10}, 10, 1'b1, 5'b00000, 3'd0};
    vecs[5] = '{"gap29_joins",  2, '{10, 10,  0,  0,  0,  0}, 29, 1'b0, 5'b00000, 3'd2};
    vecs[6] = '{"gap30_tie",    2, '{10, 10,  0,  0,  0,  0}, 30, 1'b0, 5'b00000, 3'd2};
    vecs[7] = '{"dash_dot_dash",3, '{30, 10, 20,  0,  0,  0}, 10, 1'b0, 5'b00101, 3'd3};
    vecs[8] = '{"held_sat",     1, '{100, 0,  0,  0,  0,  0}, 10, 1'b0, 5'b00001, 3'd1};

    bus.en = 1'b1;
    bus.key_in = 1'b0;
    rst = 1'b1;
    tick(3);
    vectors++;
    outs = {bus.morse_code, bus.morse_len, bus.char_valid, bus.word_gap, bus.err, bus.key_active};
    if (outs != '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, want 0", outs);
    end else $display("ok   reset_outputs");
    rst = 1'b0;
    tick(5);

    for (int v = 0; v < 9; v++) begin
      key_seq(vecs[v].n, vecs[v].press, vecs[v].gap, rel);
      push_exp(vecs[v].is_err ? EV_ERR : EV_CHAR, vecs[v].code, vecs[v].len, rel + CHAR_LAT);
      push_exp(EV_WORD, 5'b0, 3'd0, rel + WORD_LAT);
      tick(90);
      check_drained(vecs[v].name);
      $display("vec  %s applied", vecs[v].name);
    end

    // en dropped in the middle of a character: nothing may come out.
    p1 = '{10, 10, 0, 0, 0, 0};
    key_seq(2, p1, 10, rel);
    tick(10);
    bus.en = 1'b0;
    tick(1);
    vectors++;
    if (bus.morse_len != 3'd0 || bus.morse_code != 5'd0) begin
      miscompares++;
      $display("FAIL en_drop_clear: code=%b len=%0d, want 0/0", bus.morse_code, bus.morse_len);
    end else $display("ok   en_drop_clear");
    vectors++;
    if (u_dut.state_q != IDLE) begin
      miscompares++;
      $display("FAIL en_drop_state: state=%0d, want %0d", u_dut.state_q, IDLE);
    end else $display("ok   en_drop_state");
    tick(100);
    bus.en = 1'b1;
    tick(20);
    check_drained("en_drop");

    // Reset in the middle of a press, then a clean dot.
    bus.key_in = 1'b1;
    tick(15);
    rst = 1'b1;
    bus.key_in = 1'b0;
    tick(1);
    vectors++;
    outs = {bus.morse_code, bus.morse_len, bus.char_valid, bus.word_gap, bus.err, bus.key_active};
    if (outs != '0) begin
      miscompares++;
      $display("FAIL rst_mid_mark: got %b, want 0", outs);
    end else $display("ok   rst_mid_mark");
    rst = 1'b0;
    tick(20);
    p1 = '{10, 0, 0, 0, 0, 0};
    key_seq(1, p1, 10, rel);
    push_exp(EV_CHAR, 5'b00000, 3'd1, rel + CHAR_LAT);
    push_exp(EV_WORD, 5'b0, 3'd0, rel + WORD_LAT);
    tick(90);
    check_drained("after_rst_dot");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_morse_key_receiver
